// File: rtl/if_id_buf_pkg.sv
// Shared definitions for the IF/ID decoupling buffer.
//   INST_WIDTH      : default instruction width
//   INST_ADDR_WIDTH : default PC width
//   INST_NOP        : canonical NOP (addi x0,x0,0) shown to decode when no entry is valid
//   count_t         : occupancy of a 2-entry FIFO (0..2)
package if_id_buf_pkg;

    localparam int unsigned INST_WIDTH      = 32;
    localparam int unsigned INST_ADDR_WIDTH = 32;
    localparam logic [31:0] INST_NOP        = 32'h0000_0013;

    typedef logic [1:0] count_t;

endpackage

// File: rtl/if_id_buf_pp_fifo2.sv
// pp_fifo2: generic 2-entry register FIFO.
// Besides the registered count it exports the head the FIFO will hold after the
// coming edge (nxt_head/nxt_valid), so a downstream output register can show a
// freshly pushed entry with a single cycle of latency.
// Ports:
//   clk, _rst          clock, asynchronous active-low reset
//   push, pop, flush   write / read / clear-all (flush dominates)
//   wdata              data written on push
//   count              registered occupancy (0..2)
//   nxt_head           head entry after the coming edge
//   nxt_valid          FIFO is non-empty after the coming edge
module pp_fifo2
    import if_id_buf_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output count_t           count,
    output logic [WIDTH-1:0] nxt_head,
    output logic             nxt_valid
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr, rd_ptr;
    logic             wr_ptr_d, rd_ptr_d;
    count_t           count_d;
    logic             do_push, do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        count_d  = count;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr;
            if (do_pop)  rd_ptr_d = ~rd_ptr;
            if (do_push && !do_pop)      count_d = count + 2'd1;
            else if (do_pop && !do_push) count_d = count - 2'd1;
        end
    end

    // The slot being written this cycle becomes the head when the FIFO was empty,
    // or when it held one entry that is popped in the same cycle.
    always_comb begin
        nxt_valid = (count_d != 2'd0);
        if (do_push && (wr_ptr == rd_ptr_d)) nxt_head = wdata;
        else                                 nxt_head = mem[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            count  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observable after it was pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_id_buf.sv
// if_id_buf: decoupling buffer between instruction fetch and decode.
// Fetched (inst, pc) pairs go into a 2-entry FIFO; the head is presented to decode
// through registered outputs. A NOP is shown whenever no entry is valid.
// Ports:
//   clk, _rst            clock, asynchronous active-low reset
//   inst_in, pc_in       pair from fetch
//   in_valid / in_ready  fetch handshake; fetch stalls on !in_ready
//   flush                execute redirect; drops buffered and incoming entries
//   inst_out, pc_out     head pair to decode
//   out_valid / id_ready decode handshake
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int unsigned INST_W = INST_WIDTH,
    parameter int unsigned ADDR_W = INST_ADDR_WIDTH,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              _rst,
    input  logic [INST_W-1:0] inst_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              out_valid,
    input  logic              id_ready
);

    localparam int unsigned EntryW = INST_W + ADDR_W;

    count_t            count;
    logic              push, pop;
    logic [EntryW-1:0] nxt_head;
    logic              nxt_valid;

    // Only registered state feeds in_ready: no id_ready -> in_ready path.
    assign in_ready = ({30'd0, count} < DEPTH);
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = out_valid & id_ready & ~flush;

    pp_fifo2 #(
        .WIDTH (EntryW)
    ) u_fifo (
        .clk       (clk),
        ._rst      (_rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     ({inst_in, pc_in}),
        .count     (count),
        .nxt_head  (nxt_head),
        .nxt_valid (nxt_valid)
    );

    // Output register mirrors the FIFO head; pc_out keeps its last value when empty.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            out_valid <= 1'b0;
            inst_out  <= INST_W'(INST_NOP);
            pc_out    <= '0;
        end else begin
            out_valid <= nxt_valid;
            if (nxt_valid) begin
                inst_out <= nxt_head[EntryW-1:ADDR_W];
                pc_out   <= nxt_head[ADDR_W-1:0];
            end else begin
                inst_out <= INST_W'(INST_NOP);
            end
        end
    end

endmodule
